conv_job_sequencer: RTL and testbench

//  Sequences the 3x3 XNOR-popcount convolution engine across a list of matrices in input SRAM.
//  - On dut_run it walks the list, reading one header word per matrix.
//  - For each matrix it launches the engine with input base, output base and dimension.
//  - It waits for the engine's done, then moves to the next header.
//  - It stops at the terminator word, or stops with an error on an invalid header.

---
 rtl/conv_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_conv_job_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_sequencer.sv
// Walks a header list in SRAM and launches the 3x3 XNOR-popcount engine once per matrix.
// Stops with seq_done on the terminator, or raises a sticky seq_error on an invalid header.
module conv_job_sequencer #(
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 16,
  parameter int                MAX_JOBS   = 16,
  parameter logic [DATA_W-1:0] TERMINATOR = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [4:0]        job_count,
  output logic              seq_owns_port,
  output logic [ADDR_W-1:0] seq_sram_read_address,
  input  logic [DATA_W-1:0] sram_seq_read_data,
  output logic              eng_start,
  output logic [ADDR_W-1:0] eng_in_base,
  output logic [ADDR_W-1:0] eng_out_base,
  output logic [1:0]        eng_dim,
  input  logic              eng_done
);

  typedef enum logic [2:0] {
    IDLE, HDR_REQ, HDR_CHK, START, WAIT_DONE, FINISH, ERR
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] hdr_ptr_reg, out_ptr_reg, addr_reg, len_reg;
  logic [ADDR_W-1:0] in_base_reg, out_base_reg;
  logic [1:0]        dim_reg;
  logic [4:0]        job_count_reg;
  logic              busy_reg, error_reg;

  logic              hdr_is_term, hdr_is_dim, hdr_fits, job_room, hdr_accept;
  logic [ADDR_W-1:0] hdr_len;
  logic [ADDR_W:0]   hdr_end;
  logic [1:0]        dim_code;
  logic [ADDR_W-1:0] hdr_ptr_next;

  // Header decode; the end-address check carries one extra bit so overflow is visible.
  always_comb begin
    hdr_len     = ADDR_W'(sram_seq_read_data);
    hdr_is_term = (sram_seq_read_data == TERMINATOR);
    hdr_is_dim  = 1'b1;
    dim_code    = 2'b00;
    case (sram_seq_read_data)
      DATA_W'(16): dim_code = 2'b10;
      DATA_W'(12): dim_code = 2'b01;
      DATA_W'(10): dim_code = 2'b00;
      default:     hdr_is_dim = 1'b0;
    endcase
    hdr_end      = {1'b0, hdr_ptr_reg} + {1'b0, hdr_len};
    hdr_fits     = !hdr_end[ADDR_W];
    job_room     = (job_count_reg < 5'(MAX_JOBS));
    hdr_accept   = hdr_is_dim && job_room && hdr_fits;
    hdr_ptr_next = hdr_ptr_reg + len_reg + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    seq_owns_port = 1'b0;
    eng_start     = 1'b0;
    seq_done      = 1'b0;
    case (state_reg)
      IDLE:      if (dut_run) state_next = HDR_REQ;
      HDR_REQ: begin
        seq_owns_port = 1'b1;
        state_next    = HDR_CHK;
      end
      HDR_CHK: begin
        seq_owns_port = 1'b1;
        if (hdr_is_term)     state_next = FINISH;
        else if (hdr_accept) state_next = START;
        else                 state_next = ERR;
      end
      START: begin
        eng_start  = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: if (eng_done) state_next = HDR_REQ;
      FINISH: begin
        seq_done   = 1'b1;
        state_next = IDLE;
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job parameters are captured on the way into START so they stay put until eng_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_ptr_reg   <= '0;
      out_ptr_reg   <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      in_base_reg   <= '0;
      out_base_reg  <= '0;
      dim_reg       <= '0;
      job_count_reg <= '0;
      busy_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (dut_run) begin
          hdr_ptr_reg   <= '0;
          out_ptr_reg   <= '0;
          addr_reg      <= '0;
          job_count_reg <= '0;
          error_reg     <= 1'b0;
          busy_reg      <= 1'b1;
        end
        HDR_CHK: begin
          if (!hdr_is_term && hdr_accept) begin
            len_reg      <= hdr_len;
            in_base_reg  <= hdr_ptr_reg + ADDR_W'(1);
            out_base_reg <= out_ptr_reg;
            dim_reg      <= dim_code;
          end else if (!hdr_is_term) begin
            error_reg <= 1'b1;
          end
        end
        WAIT_DONE: if (eng_done) begin
          hdr_ptr_reg   <= hdr_ptr_next;
          addr_reg      <= hdr_ptr_next;
          out_ptr_reg   <= out_ptr_reg + len_reg - ADDR_W'(2);
          job_count_reg <= job_count_reg + 5'd1;
        end
        FINISH, ERR: busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign dut_busy              = busy_reg;
  assign seq_error             = error_reg;
  assign job_count             = job_count_reg;
  assign seq_sram_read_address = addr_reg;
  assign eng_in_base           = in_base_reg;
  assign eng_out_base          = out_base_reg;
  assign eng_dim               = dim_reg;

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer: SRAM and engine models, expected jobs queued
// when the header list is written and compared as each eng_start appears.
module tb_conv_job_sequencer;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic [1:0]        dim;
  } exp_t;

  logic              clk, reset, dut_run, dut_busy, seq_done, seq_error;
  logic [4:0]        job_count;
  logic              seq_owns_port, eng_start, eng_done;
  logic [ADDR_W-1:0] seq_sram_read_address, eng_in_base, eng_out_base;
  logic [DATA_W-1:0] sram_seq_read_data;
  logic [1:0]        eng_dim;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;

  conv_job_sequencer dut (
    .clk                   (clk),
    .reset                 (reset),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .seq_done              (seq_done),
    .seq_error             (seq_error),
    .job_count             (job_count),
    .seq_owns_port         (seq_owns_port),
    .seq_sram_read_address (seq_sram_read_address),
    .sram_seq_read_data    (sram_seq_read_data),
    .eng_start             (eng_start),
    .eng_in_base           (eng_in_base),
    .eng_out_base          (eng_out_base),
    .eng_dim               (eng_dim),
    .eng_done              (eng_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM: data appears the cycle after the address.
  always @(posedge clk) sram_seq_read_data <= mem[seq_sram_read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  endtask

  task automatic push_exp(input int in_b, input int out_b, input logic [1:0] d);
    exp_t e;
    e.in_base  = ADDR_W'(in_b);
    e.out_base = ADDR_W'(out_b);
    e.dim      = d;
    exp_q.push_back(e);
  endtask

  // Starts a run at the current negedge and plays the engine until dut_busy drops.
  task automatic run_list(input int exp_jobs, input bit exp_err, input bit glitch, input int delay);
    int   cyc, starts, eng_cnt, done_cyc;
    bit   saw_done;
    exp_t e;
    cyc = 1; starts = 0; eng_cnt = -1; done_cyc = 0; saw_done = 0; e = '0;
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    check("busy_after_run", 32'(dut_busy), 1);
    while (cyc < 1000) begin
      eng_done = 1'b0;
      if (glitch && cyc == done_cyc + 2) eng_done = 1'b1;
      if (eng_start) begin
        starts++;
        check("start_latency", 32'(cyc - done_cyc), 3);
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(starts), 32'(exp_jobs));
        end else begin
          e = exp_q.pop_front();
          check("in_base", 32'(eng_in_base), 32'(e.in_base));
          check("out_base", 32'(eng_out_base), 32'(e.out_base));
          check("dim", 32'(eng_dim), 32'(e.dim));
        end
        if (glitch) eng_done = 1'b1;
        eng_cnt = delay;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
      end else if (eng_cnt == 0) begin
        check("in_base_held", 32'(eng_in_base), 32'(e.in_base));
        check("out_base_held", 32'(eng_out_base), 32'(e.out_base));
        check("dim_held", 32'(eng_dim), 32'(e.dim));
        eng_done = 1'b1;
        done_cyc = cyc;
        eng_cnt  = -1;
      end
      if (seq_done) begin
        saw_done = 1'b1;
        check("job_count_at_done", 32'(job_count), 32'(exp_jobs));
      end
      if (!dut_busy) break;
      @(negedge clk);
      cyc++;
    end
    eng_done = 1'b0;
    check("run_bounded", 32'(cyc < 1000), 1);
    check("start_count", 32'(starts), 32'(exp_jobs));
    check("seq_done_seen", 32'(saw_done), 32'(!exp_err));
    check("seq_error", 32'(seq_error), 32'(exp_err));
    check("job_count_final", 32'(job_count), 32'(exp_jobs));
    check("queue_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1; dut_run = 1'b0; eng_done = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(dut_busy), 0);
    check("rst_done", 32'(seq_done), 0);
    check("rst_error", 32'(seq_error), 0);
    check("rst_job_count", 32'(job_count), 0);
    check("rst_owns", 32'(seq_owns_port), 0);
    check("rst_addr", 32'(seq_sram_read_address), 0);
    check("rst_start", 32'(eng_start), 0);
    check("rst_in_base", 32'(eng_in_base), 0);

    // Single 16x16 matrix
    clear_mem();
    mem[0] = 16'd16; mem[17] = 16'h00FF;
    push_exp(1, 0, 2'b10);
    run_list(1, 1'b0, 1'b0, 2);

    // Three matrices of mixed dimension
    clear_mem();
    mem[0] = 16'd10; mem[11] = 16'd12; mem[24] = 16'd16; mem[41] = 16'h00FF;
    push_exp(1, 0, 2'b00); push_exp(12, 8, 2'b01); push_exp(25, 18, 2'b10);
    run_list(3, 1'b0, 1'b0, 4);

    // Invalid header value
    clear_mem();
    mem[0] = 16'd11;
    dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    check("err_busy_c1", 32'(dut_busy), 1);
    @(negedge clk);
    check("err_owns_c2", 32'(seq_owns_port), 1);
    @(negedge clk);
    check("err_flag_c3", 32'(seq_error), 1);
    check("err_busy_c3", 32'(dut_busy), 1);
    check("err_no_start", 32'(eng_start), 0);
    @(negedge clk);
    check("err_busy_c4", 32'(dut_busy), 0);
    check("err_sticky", 32'(seq_error), 1);

    // Spurious eng_done in HDR_CHK and START must be ignored
    clear_mem();
    mem[0] = 16'd16; mem[17] = 16'd10; mem[28] = 16'h00FF;
    push_exp(1, 0, 2'b10); push_exp(18, 14, 2'b00);
    run_list(2, 1'b0, 1'b1, 3);

    // Reset while the engine is running, then a clean rerun
    clear_mem();
    mem[0] = 16'd10; mem[11] = 16'd12; mem[24] = 16'd16; mem[41] = 16'h00FF;
    dut_run = 1'b1;
    @(negedge clk); dut_run = 1'b0;
    n = 0;
    while (!eng_start && n < 20) begin
      @(negedge clk); n++;
    end
    check("rr_start_seen", 32'(eng_start), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rr_busy", 32'(dut_busy), 0);
    check("rr_job_count", 32'(job_count), 0);
    check("rr_in_base", 32'(eng_in_base), 0);
    check("rr_addr", 32'(seq_sram_read_address), 0);
    check("rr_start", 32'(eng_start), 0);
    push_exp(1, 0, 2'b00); push_exp(12, 8, 2'b01); push_exp(25, 18, 2'b10);
    run_list(3, 1'b0, 1'b0, 1);

    // Job limit: one header more than MAX_JOBS and no terminator
    clear_mem();
    for (int k = 0; k < 17; k++) mem[11*k] = 16'd10;
    for (int k = 0; k < 16; k++) push_exp(11*k + 1, 8*k, 2'b00);
    run_list(16, 1'b1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
